// File: rtl/demux_sched_1to4_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_sched_1to4_pkg                                             |
// | Shared types and constants for the 1-to-4 demux scheduler.       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package demux_sched_1to4_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        XFER   = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/demux_sched_1to4_rr_pick4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick4                                                         |
// | Combinational round-robin picker: first set mask bit after last. |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module rr_pick4
    import demux_sched_1to4_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] grant,
    output logic             any
);

    logic w_found;

    // Offsets 1..4 visit last+1, last+2, last+3 and finally last itself.
    always_comb begin
        grant   = last;
        w_found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            if (!w_found && mask[last + SEL_W'(i)]) begin
                grant   = last + SEL_W'(i);
                w_found = 1'b1;
            end
        end
    end

    assign any = |mask;

endmodule
`default_nettype wire

// File: rtl/demux_sched_1to4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_sched_1to4                                                 |
// | Round-robin burst scheduler driving a 1-to-4 demux datapath.     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module demux_sched_1to4
    import demux_sched_1to4_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DWELL = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [NCH-1:0]   EN_MASK,
    input  logic [NCH-1:0]   OUT_READY,
    output logic [SEL_W-1:0] SEL,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [NCH-1:0]   OUT_VALID,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(DWELL - 1);
    localparam logic [NCH-1:0]   c_onehot0   = NCH'(1);

    sched_state_t     r_state;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] w_grant;
    logic             w_any;
    logic             w_xfer;

    rr_pick4 u_pick (
        .mask  (EN_MASK),
        .last  (r_sel),
        .grant (w_grant),
        .any   (w_any)
    );

    assign IN_READY = (r_state == XFER) & EN_MASK[r_sel] & OUT_READY[r_sel];
    assign w_xfer   = IN_VALID & IN_READY;
    assign SEL      = r_sel;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_sel     <= 2'b11;
            r_cnt     <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= '0;
            BUSY      <= 1'b0;
        end else begin
            OUT_VALID <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= SELECT;
                        BUSY    <= 1'b1;
                    end
                end
                SELECT: begin
                    if (w_any) begin
                        r_sel   <= w_grant;
                        r_cnt   <= '0;
                        r_state <= XFER;
                    end else begin
                        r_state <= IDLE;
                        BUSY    <= 1'b0;
                    end
                end
                XFER: begin
                    // A dropped enable abandons the burst; no beat is taken.
                    if (!EN_MASK[r_sel]) begin
                        r_state <= SELECT;
                    end else if (w_xfer) begin
                        OUT_DATA  <= IN;
                        OUT_VALID <= c_onehot0 << r_sel;
                        r_cnt     <= r_cnt + 1'b1;
                        if (r_cnt == c_last_beat) begin
                            r_state <= SELECT;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
